inst_ram_responder: RTL and testbench

- Responder end of the instruction-fetch SRAM interface: accepts the fetch stage's inst_sram_en/inst_sram_addr requests and returns inst_sram_rdata.
- Drives the board's asynchronous BaseRAM pins, read-only; no write path.
- Sits between the fetch stage and the BaseRAM pad ring.
- Supports zero-wait operation (data in the cycle after the request, as fetch currently expects) and configurable wait states, with a busy/valid handshake.

---
 rtl/inst_ram_responder.sv | 181 ++++++++++++++++++
 tb/tb_inst_ram_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_ram_responder.sv
// Read-only responder that serves instruction fetches from the board's asynchronous BaseRAM.
// Optional macro INST_RAM_LAST_HIT_EN: a repeat of the last in-window word is served without an SRAM access.
module inst_ram_responder #(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned WIN_BITS    = 22,
    parameter logic [31:0] ERR_DATA    = 32'h0340_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_en,
    input  logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_rdata,
    output logic        inst_sram_rvalid,
    output logic        inst_sram_busy,
    output logic        inst_addr_err,
    output logic [19:0] base_ram_addr,
    input  logic [31:0] base_ram_data_i,
    output logic        base_ram_ce_n,
    output logic        base_ram_oe_n,
    output logic        base_ram_we_n,
    output logic [3:0]  base_ram_be_n
);

    localparam int unsigned CNT_W     = 3;
    localparam bit          HAS_WAIT  = (WAIT_CYCLES != 0);
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        HAS_WAIT ? CNT_W'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [19:0]        addr_q, addr_d;
    logic               win_q, win_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic [31:0]        offset_c;
    logic               in_win_c;
    logic               accept_c;
    logic               hit_c;
    logic               ext_c;
    logic               done_c;
    logic               done_win_c;

    // Window test wraps modulo 2^32 so addresses below BASE_ADDR fall out of range.
    assign offset_c = inst_sram_addr - BASE_ADDR;
    assign in_win_c = ((offset_c >> WIN_BITS) == 32'd0);
    assign accept_c = resetn && inst_sram_en && (state_q != S_WAIT);

`ifdef INST_RAM_LAST_HIT_EN
    logic [19:0] tag_q, tag_d;
    logic        tag_vld_q, tag_vld_d;

    assign hit_c = accept_c && in_win_c && tag_vld_q &&
                   (tag_q == inst_sram_addr[21:2]);
`else
    assign hit_c = 1'b0;
`endif

    assign ext_c = accept_c && in_win_c && !hit_c;

    // Next-state, capture and completion logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        win_d      = win_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        err_d      = 1'b0;
        done_c     = 1'b0;
        done_win_c = 1'b0;

        case (state_q)
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = S_RESP;
                    done_c     = 1'b1;
                    done_win_c = win_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept_c) begin
            win_d = in_win_c;
            if (ext_c) begin
                addr_d = inst_sram_addr[21:2];
            end
            if (hit_c) begin
                state_d  = S_RESP;
                rvalid_d = 1'b1;
            end else if (HAS_WAIT) begin
                state_d = S_WAIT;
                cnt_d   = WAIT_LOAD;
            end else begin
                state_d    = S_RESP;
                done_c     = 1'b1;
                done_win_c = in_win_c;
            end
        end

        if (done_c) begin
            rvalid_d = 1'b1;
            rdata_d  = done_win_c ? base_ram_data_i : ERR_DATA;
            err_d    = !done_win_c;
        end

        busy_d = (state_d == S_WAIT);
    end

`ifdef INST_RAM_LAST_HIT_EN
    // Tag follows the last completed read; an error completion invalidates it so held rdata stays a real word.
    always_comb begin
        tag_d     = tag_q;
        tag_vld_d = tag_vld_q;
        if (done_c) begin
            tag_d     = addr_d;
            tag_vld_d = done_win_c;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag_q     <= '0;
            tag_vld_q <= 1'b0;
        end else begin
            tag_q     <= tag_d;
            tag_vld_q <= tag_vld_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            win_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            win_q    <= win_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    // Pins are live in the accept cycle and throughout in-window wait states.
    logic ram_en_c;
    assign ram_en_c = ext_c || ((state_q == S_WAIT) && win_q);

    assign base_ram_addr    = ext_c ? inst_sram_addr[21:2] : addr_q;
    assign base_ram_ce_n    = !ram_en_c;
    assign base_ram_oe_n    = !ram_en_c;
    assign base_ram_we_n    = 1'b1;
    assign base_ram_be_n    = 4'b0000;

    assign inst_sram_rdata  = rdata_q;
    assign inst_sram_rvalid = rvalid_q;
    assign inst_sram_busy   = busy_q;
    assign inst_addr_err    = err_q;

endmodule

// File: tb/tb_inst_ram_responder.sv
// Directed bench: three responders (0, 2 and 3 wait states) against a pattern SRAM returning {12'hABC, word}.
module tb_inst_ram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    localparam logic [31:0] ERR = 32'h0340_0000;

    logic        rst0, en0, rv0, bz0, er0, ce0, oe0, we0;
    logic [31:0] ad0, rd0, di0;
    logic [19:0] ra0;
    logic [3:0]  be0;
    logic        rst2, en2, rv2, bz2, er2, ce2, oe2, we2;
    logic [31:0] ad2, rd2, di2;
    logic [19:0] ra2;
    logic [3:0]  be2;
    logic        rst3, en3, rv3, bz3, er3, ce3, oe3, we3;
    logic [31:0] ad3, rd3, di3;
    logic [19:0] ra3;
    logic [3:0]  be3;

    assign di0 = {12'hABC, ra0};
    assign di2 = {12'hABC, ra2};
    assign di3 = {12'hABC, ra3};

    inst_ram_responder #(.WAIT_CYCLES(0)) u0 (
        .clk(clk), .resetn(rst0), .inst_sram_en(en0), .inst_sram_addr(ad0),
        .inst_sram_rdata(rd0), .inst_sram_rvalid(rv0), .inst_sram_busy(bz0),
        .inst_addr_err(er0), .base_ram_addr(ra0), .base_ram_data_i(di0),
        .base_ram_ce_n(ce0), .base_ram_oe_n(oe0), .base_ram_we_n(we0), .base_ram_be_n(be0));

    inst_ram_responder #(.WAIT_CYCLES(2)) u2 (
        .clk(clk), .resetn(rst2), .inst_sram_en(en2), .inst_sram_addr(ad2),
        .inst_sram_rdata(rd2), .inst_sram_rvalid(rv2), .inst_sram_busy(bz2),
        .inst_addr_err(er2), .base_ram_addr(ra2), .base_ram_data_i(di2),
        .base_ram_ce_n(ce2), .base_ram_oe_n(oe2), .base_ram_we_n(we2), .base_ram_be_n(be2));

    inst_ram_responder #(.WAIT_CYCLES(3)) u3 (
        .clk(clk), .resetn(rst3), .inst_sram_en(en3), .inst_sram_addr(ad3),
        .inst_sram_rdata(rd3), .inst_sram_rvalid(rv3), .inst_sram_busy(bz3),
        .inst_addr_err(er3), .base_ram_addr(ra3), .base_ram_data_i(di3),
        .base_ram_ce_n(ce3), .base_ram_oe_n(oe3), .base_ram_we_n(we3), .base_ram_be_n(be3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        rst0 = 1'b0; en0 = 1'b0; ad0 = '0;
        rst2 = 1'b0; en2 = 1'b0; ad2 = '0;
        rst3 = 1'b0; en3 = 1'b0; ad3 = '0;
        repeat (2) neg();

        // Reset state
        chk ("rst_rdata0", rd0, 32'h0);
        chk1("rst_rvalid0", rv0, 1'b0);
        chk1("rst_busy0", bz0, 1'b0);
        chk1("rst_err0", er0, 1'b0);
        chk1("rst_ce0", ce0, 1'b1);
        chk1("rst_oe0", oe0, 1'b1);
        chk1("rst_we0", we0, 1'b1);
        chk ("rst_be0", {28'h0, be0}, 32'h0);
        chk1("rst_oe2", oe2, 1'b1);
        chk1("rst_we2", we2, 1'b1);
        chk ("rst_be2", {28'h0, be2}, 32'h0);
        chk1("rst_err2", er2, 1'b0);
        chk1("rst_oe3", oe3, 1'b1);
        chk1("rst_we3", we3, 1'b1);
        chk ("rst_be3", {28'h0, be3}, 32'h0);
        chk1("rst_err3", er3, 1'b0);
        rst0 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        step();

        // Zero-wait burst, one request per cycle
        en0 = 1'b1; ad0 = 32'h8000_0000; neg();
        chk ("w0_ra_a", {12'h0, ra0}, 32'h0);
        chk1("w0_ce_a", ce0, 1'b0);
        chk1("w0_oe_a", oe0, 1'b0);
        chk1("w0_busy_a", bz0, 1'b0);
        step(); ad0 = 32'h8000_0004; neg();
        chk1("w0_rv_1", rv0, 1'b1);
        chk ("w0_rd_1", rd0, 32'hABC0_0000);
        chk ("w0_ra_b", {12'h0, ra0}, 32'h1);
        chk1("w0_busy_b", bz0, 1'b0);
        step(); ad0 = 32'h8000_0008; neg();
        chk1("w0_rv_2", rv0, 1'b1);
        chk ("w0_rd_2", rd0, 32'hABC0_0001);
        chk ("w0_ra_c", {12'h0, ra0}, 32'h2);
        step(); en0 = 1'b0; neg();
        chk1("w0_rv_3", rv0, 1'b1);
        chk ("w0_rd_3", rd0, 32'hABC0_0002);
        chk1("w0_busy_c", bz0, 1'b0);
        chk1("w0_ce_idle", ce0, 1'b1);

        // Idle hold
        for (int i = 0; i < 5; i++) begin
            step(); neg();
            chk1("idle_rv", rv0, 1'b0);
            chk ("idle_rd", rd0, 32'hABC0_0002);
            chk1("idle_ce", ce0, 1'b1);
        end

        // Out-of-window above and below, then last valid word
        step(); en0 = 1'b1; ad0 = 32'h8040_0000; neg();
        chk1("oow_hi_ce", ce0, 1'b1);
        chk ("oow_hi_ra", {12'h0, ra0}, 32'h2);
        step(); ad0 = 32'h0000_0000; neg();
        chk1("oow_hi_rv", rv0, 1'b1);
        chk1("oow_hi_err", er0, 1'b1);
        chk ("oow_hi_rd", rd0, ERR);
        chk1("oow_lo_ce", ce0, 1'b1);
        chk ("oow_lo_ra", {12'h0, ra0}, 32'h2);
        step(); ad0 = 32'h803F_FFFC; neg();
        chk1("oow_lo_rv", rv0, 1'b1);
        chk1("oow_lo_err", er0, 1'b1);
        chk ("oow_lo_rd", rd0, ERR);
        chk1("last_ce", ce0, 1'b0);
        chk ("last_ra", {12'h0, ra0}, 32'hF_FFFF);
        step(); en0 = 1'b0; neg();
        chk1("last_rv", rv0, 1'b1);
        chk1("last_err", er0, 1'b0);
        chk ("last_rd", rd0, 32'hABCF_FFFF);
        step(); neg();
        chk1("post_rv", rv0, 1'b0);
        chk1("post_err", er0, 1'b0);

        // Two wait states; request held during busy is dropped
        step(); en2 = 1'b1; ad2 = 32'h8000_0010; neg();
        chk1("w2_ce_n", ce2, 1'b0);
        chk1("w2_busy_n", bz2, 1'b0);
        chk ("w2_ra_n", {12'h0, ra2}, 32'h4);
        step(); ad2 = 32'h8000_0030; neg();
        chk1("w2_busy_1", bz2, 1'b1);
        chk1("w2_ce_1", ce2, 1'b0);
        chk ("w2_ra_1", {12'h0, ra2}, 32'h4);
        chk1("w2_rv_1", rv2, 1'b0);
        step(); neg();
        chk1("w2_busy_2", bz2, 1'b1);
        chk1("w2_ce_2", ce2, 1'b0);
        chk ("w2_ra_2", {12'h0, ra2}, 32'h4);
        step(); en2 = 1'b0; neg();
        chk1("w2_rv_3", rv2, 1'b1);
        chk ("w2_rd_3", rd2, 32'hABC0_0004);
        chk1("w2_busy_3", bz2, 1'b0);
        chk1("w2_ce_3", ce2, 1'b1);
        step(); neg();
        chk1("w2_drop_rv", rv2, 1'b0);
        chk1("w2_drop_ce", ce2, 1'b1);

        // Repeat read of one word
        step(); en2 = 1'b1; ad2 = 32'h8000_0020; neg();
        chk1("rep1_ce", ce2, 1'b0);
        step(); en2 = 1'b0; neg();
        chk1("rep1_busy", bz2, 1'b1);
        step(); neg();
        step(); neg();
        chk1("rep1_rv", rv2, 1'b1);
        chk ("rep1_rd", rd2, 32'hABC0_0008);
        step(); en2 = 1'b1; ad2 = 32'h8000_0020; neg();
`ifdef INST_RAM_LAST_HIT_EN
        chk1("hit_ce", ce2, 1'b1);
        step(); en2 = 1'b0; neg();
        chk1("hit_rv", rv2, 1'b1);
        chk ("hit_rd", rd2, 32'hABC0_0008);
        chk1("hit_busy", bz2, 1'b0);
        chk1("hit_ce_after", ce2, 1'b1);
`else
        chk1("rep2_ce", ce2, 1'b0);
        step(); en2 = 1'b0; neg();
        chk1("rep2_busy", bz2, 1'b1);
        chk1("rep2_rv_early", rv2, 1'b0);
        step(); neg();
        step(); neg();
        chk1("rep2_rv", rv2, 1'b1);
        chk ("rep2_rd", rd2, 32'hABC0_0008);
`endif
        step(); neg();
        chk1("rep_quiet_rv", rv2, 1'b0);

        // Reset between repeats forces a fresh external access
        rst2 = 1'b0; #1;
        chk ("rst2_rd", rd2, 32'h0);
        #2 rst2 = 1'b1;
        step(); en2 = 1'b1; ad2 = 32'h8000_0020; neg();
        chk1("rst2_ce", ce2, 1'b0);
        chk ("rst2_ra", {12'h0, ra2}, 32'h8);
        step(); en2 = 1'b0; neg();
        chk1("rst2_busy", bz2, 1'b1);
        step(); neg();
        step(); neg();
        chk1("rst2_rv", rv2, 1'b1);
        chk ("rst2_rdv", rd2, 32'hABC0_0008);

        // Three wait states: one full read, then a reset mid-access
        step(); en3 = 1'b1; ad3 = 32'h8000_0044; neg();
        chk1("w3_ce_n", ce3, 1'b0);
        step(); en3 = 1'b0; neg();
        chk1("w3_busy_1", bz3, 1'b1);
        step(); neg();
        step(); neg();
        chk1("w3_rv_early", rv3, 1'b0);
        step(); neg();
        chk1("w3_rv", rv3, 1'b1);
        chk ("w3_rd", rd3, 32'hABC0_0011);
        step(); en3 = 1'b1; ad3 = 32'h8000_0040; neg();
        chk1("ab_ce_n", ce3, 1'b0);
        step(); en3 = 1'b0; neg();
        chk1("ab_busy_1", bz3, 1'b1);
        chk1("ab_ce_1", ce3, 1'b0);
        step(); #2;
        chk1("ab_busy_2", bz3, 1'b1);
        rst3 = 1'b0; #1;
        chk1("ab_ce", ce3, 1'b1);
        chk1("ab_busy", bz3, 1'b0);
        chk1("ab_rv", rv3, 1'b0);
        chk ("ab_rd", rd3, 32'h0);
        neg(); rst3 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(); neg();
            chk1("ab_post_rv", rv3, 1'b0);
            chk1("ab_post_ce", ce3, 1'b1);
            chk1("ab_post_busy", bz3, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
